// File: rtl/id_ex_latch.sv
// id_ex_latch
// ID/EX pipeline register of the 5-stage MIPS pipeline. It captures the
// decoded instruction on every enabled edge and inserts a bubble on flush,
// after a halt has been seen, or on a load-use hazard. It also raises a
// combinational stall request (luStall) back to the PC and the IF/ID latch.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   en                   pipeline advance; registers hold while low
//   flush                squash; the next enabled edge loads a bubble
//   *_in_1               decoded fields from the ID stage
//   *_out_2              registered fields presented to EX and forwarding
//   luStall              load-use stall request (combinational)
module id_ex_latch (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        en,
   input  logic        flush,
   input  logic        valid_in_1,
   input  logic        halt_in_1,
   input  logic        RegWrite_in_1,
   input  logic        dREN_in_1,
   input  logic        dWEN_in_1,
   input  logic        alusrc_in_1,
   input  logic        uses_rt_in_1,
   input  logic [4:0]  rs_in_1,
   input  logic [4:0]  rt_in_1,
   input  logic [4:0]  wsel_in_1,
   input  logic [3:0]  aluop_in_1,
   input  logic [31:0] rdat1_in_1,
   input  logic [31:0] rdat2_in_1,
   input  logic [31:0] imm_in_1,
   input  logic [31:0] pc4_in_1,
   output logic        valid_out_2,
   output logic        halt_out_2,
   output logic        RegWrite_out_2,
   output logic        dREN_out_2,
   output logic        dWEN_out_2,
   output logic        alusrc_out_2,
   output logic [4:0]  rs_out_2,
   output logic [4:0]  rt_out_2,
   output logic [4:0]  wsel_out_2,
   output logic [3:0]  aluop_out_2,
   output logic [31:0] rdat1_out_2,
   output logic [31:0] rdat2_out_2,
   output logic [31:0] imm_out_2,
   output logic [31:0] pc4_out_2,
   output logic        luStall
);

   logic haltReg;
   logic haltSeen;
   logic srcMatch;

   // A load into $zero never creates a dependency; rt only counts when the
   // consumer actually reads it.
   always_comb begin
      srcMatch = (wsel_out_2 == rs_in_1) |
                 (uses_rt_in_1 & (wsel_out_2 == rt_in_1));
      luStall  = valid_out_2 & dREN_out_2 & (wsel_out_2 != 5'd0) &
                 valid_in_1 & srcMatch & ~flush & ~haltSeen;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_out_2    <= 1'b0;
         haltReg        <= 1'b0;
         RegWrite_out_2 <= 1'b0;
         dREN_out_2     <= 1'b0;
         dWEN_out_2     <= 1'b0;
         alusrc_out_2   <= 1'b0;
         rs_out_2       <= 5'd0;
         rt_out_2       <= 5'd0;
         wsel_out_2     <= 5'd0;
         aluop_out_2    <= 4'd0;
         rdat1_out_2    <= 32'd0;
         rdat2_out_2    <= 32'd0;
         imm_out_2      <= 32'd0;
         pc4_out_2      <= 32'd0;
         haltSeen       <= 1'b0;
      end else if (en) begin
         if (flush || haltSeen || luStall) begin
            valid_out_2    <= 1'b0;
            haltReg        <= 1'b0;
            RegWrite_out_2 <= 1'b0;
            dREN_out_2     <= 1'b0;
            dWEN_out_2     <= 1'b0;
            alusrc_out_2   <= 1'b0;
            rs_out_2       <= 5'd0;
            rt_out_2       <= 5'd0;
            wsel_out_2     <= 5'd0;
            aluop_out_2    <= 4'd0;
            rdat1_out_2    <= 32'd0;
            rdat2_out_2    <= 32'd0;
            imm_out_2      <= 32'd0;
            pc4_out_2      <= 32'd0;
         end else begin
            valid_out_2    <= valid_in_1;
            haltReg        <= halt_in_1;
            RegWrite_out_2 <= RegWrite_in_1;
            dREN_out_2     <= dREN_in_1;
            dWEN_out_2     <= dWEN_in_1;
            alusrc_out_2   <= alusrc_in_1;
            rs_out_2       <= rs_in_1;
            rt_out_2       <= rt_in_1;
            wsel_out_2     <= wsel_in_1;
            aluop_out_2    <= aluop_in_1;
            rdat1_out_2    <= rdat1_in_1;
            rdat2_out_2    <= rdat2_in_1;
            imm_out_2      <= imm_in_1;
            pc4_out_2      <= pc4_in_1;
            if (halt_in_1)
               haltSeen <= 1'b1;
         end
      end
   end

   // haltSeen keeps halt visible to EX after the halt itself has been
   // replaced by bubbles.
   assign halt_out_2 = haltReg | haltSeen;

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        en, flush;
   logic        valid_in_1, halt_in_1, RegWrite_in_1, dREN_in_1, dWEN_in_1;
   logic        alusrc_in_1, uses_rt_in_1;
   logic [4:0]  rs_in_1, rt_in_1, wsel_in_1;
   logic [3:0]  aluop_in_1;
   logic [31:0] rdat1_in_1, rdat2_in_1, imm_in_1, pc4_in_1;
   logic        valid_out_2, halt_out_2, RegWrite_out_2, dREN_out_2;
   logic        dWEN_out_2, alusrc_out_2;
   logic [4:0]  rs_out_2, rt_out_2, wsel_out_2;
   logic [3:0]  aluop_out_2;
   logic [31:0] rdat1_out_2, rdat2_out_2, imm_out_2, pc4_out_2;
   logic        luStall;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   id_ex_latch dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .valid_in_1(valid_in_1), .halt_in_1(halt_in_1),
      .RegWrite_in_1(RegWrite_in_1), .dREN_in_1(dREN_in_1),
      .dWEN_in_1(dWEN_in_1), .alusrc_in_1(alusrc_in_1),
      .uses_rt_in_1(uses_rt_in_1), .rs_in_1(rs_in_1), .rt_in_1(rt_in_1),
      .wsel_in_1(wsel_in_1), .aluop_in_1(aluop_in_1),
      .rdat1_in_1(rdat1_in_1), .rdat2_in_1(rdat2_in_1),
      .imm_in_1(imm_in_1), .pc4_in_1(pc4_in_1),
      .valid_out_2(valid_out_2), .halt_out_2(halt_out_2),
      .RegWrite_out_2(RegWrite_out_2), .dREN_out_2(dREN_out_2),
      .dWEN_out_2(dWEN_out_2), .alusrc_out_2(alusrc_out_2),
      .rs_out_2(rs_out_2), .rt_out_2(rt_out_2), .wsel_out_2(wsel_out_2),
      .aluop_out_2(aluop_out_2), .rdat1_out_2(rdat1_out_2),
      .rdat2_out_2(rdat2_out_2), .imm_out_2(imm_out_2),
      .pc4_out_2(pc4_out_2), .luStall(luStall)
   );

   // Reference model: the instruction currently sitting in EX, plus a flag
   // saying a halt has already entered EX.
   typedef struct {
      logic        valid, halt, regWrite, dren, dwen, alusrc;
      logic [4:0]  rs, rt, wsel;
      logic [3:0]  aluop;
      logic [31:0] rdat1, rdat2, imm, pc4;
   } instr_t;

   instr_t exInstr;
   logic   haltEntered;

   function automatic instr_t bubble();
      instr_t b;
      b = '{valid: 1'b0, halt: 1'b0, regWrite: 1'b0, dren: 1'b0, dwen: 1'b0,
            alusrc: 1'b0, rs: 5'd0, rt: 5'd0, wsel: 5'd0, aluop: 4'd0,
            rdat1: 32'd0, rdat2: 32'd0, imm: 32'd0, pc4: 32'd0};
      return b;
   endfunction

   function automatic instr_t idInstr();
      instr_t i;
      i = '{valid: valid_in_1, halt: halt_in_1, regWrite: RegWrite_in_1,
            dren: dREN_in_1, dwen: dWEN_in_1, alusrc: alusrc_in_1,
            rs: rs_in_1, rt: rt_in_1, wsel: wsel_in_1, aluop: aluop_in_1,
            rdat1: rdat1_in_1, rdat2: rdat2_in_1, imm: imm_in_1,
            pc4: pc4_in_1};
      return i;
   endfunction

   // A valid load in EX whose nonzero destination is read by a valid ID
   // instruction; never while squashing or after a halt.
   function automatic logic hazardExpected();
      logic reads;
      if (flush || haltEntered) return 1'b0;
      if (!(exInstr.valid && exInstr.dren && exInstr.wsel != 5'd0 && valid_in_1))
         return 1'b0;
      reads = (exInstr.wsel == rs_in_1) ||
              (uses_rt_in_1 && exInstr.wsel == rt_in_1);
      return reads;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutputs();
      chk("valid",    {31'd0, valid_out_2},    {31'd0, exInstr.valid});
      chk("halt",     {31'd0, halt_out_2},     {31'd0, exInstr.halt | haltEntered});
      chk("regWrite", {31'd0, RegWrite_out_2}, {31'd0, exInstr.regWrite});
      chk("dREN",     {31'd0, dREN_out_2},     {31'd0, exInstr.dren});
      chk("dWEN",     {31'd0, dWEN_out_2},     {31'd0, exInstr.dwen});
      chk("alusrc",   {31'd0, alusrc_out_2},   {31'd0, exInstr.alusrc});
      chk("rs",       {27'd0, rs_out_2},       {27'd0, exInstr.rs});
      chk("rt",       {27'd0, rt_out_2},       {27'd0, exInstr.rt});
      chk("wsel",     {27'd0, wsel_out_2},     {27'd0, exInstr.wsel});
      chk("aluop",    {28'd0, aluop_out_2},    {28'd0, exInstr.aluop});
      chk("rdat1",    rdat1_out_2, exInstr.rdat1);
      chk("rdat2",    rdat2_out_2, exInstr.rdat2);
      chk("imm",      imm_out_2,   exInstr.imm);
      chk("pc4",      pc4_out_2,   exInstr.pc4);
   endtask

   task automatic modelReset();
      exInstr     = bubble();
      haltEntered = 1'b0;
   endtask

   task automatic setIdle();
      en = 1'b1; flush = 1'b0;
      valid_in_1 = 1'b0; halt_in_1 = 1'b0; RegWrite_in_1 = 1'b0;
      dREN_in_1 = 1'b0; dWEN_in_1 = 1'b0; alusrc_in_1 = 1'b0;
      uses_rt_in_1 = 1'b0; rs_in_1 = 5'd0; rt_in_1 = 5'd0; wsel_in_1 = 5'd0;
      aluop_in_1 = 4'd0; rdat1_in_1 = 32'd0; rdat2_in_1 = 32'd0;
      imm_in_1 = 32'd0; pc4_in_1 = 32'd0;
   endtask

   task automatic randomInputs();
      en            = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      valid_in_1    = ($urandom_range(0, 4) != 0);
      halt_in_1     = ($urandom_range(0, 59) == 0);
      RegWrite_in_1 = 1'($urandom);
      dREN_in_1     = 1'($urandom);
      dWEN_in_1     = 1'($urandom);
      alusrc_in_1   = 1'($urandom);
      uses_rt_in_1  = 1'($urandom);
      rs_in_1       = 5'($urandom_range(0, 3));
      rt_in_1       = 5'($urandom_range(0, 3));
      wsel_in_1     = 5'($urandom_range(0, 3));
      aluop_in_1    = 4'($urandom);
      rdat1_in_1    = $urandom;
      rdat2_in_1    = $urandom;
      imm_in_1      = $urandom;
      pc4_in_1      = $urandom;
   endtask

   // Called just after a falling edge with inputs settled: checks the stall
   // request, advances across one rising edge, then checks the registers.
   task automatic cycle();
      logic expHaz;
      #1;
      expHaz = hazardExpected();
      chk("luStall", {31'd0, luStall}, {31'd0, expHaz});
      @(posedge CLK);
      if (en) begin
         if (flush || haltEntered || expHaz) exInstr = bubble();
         else begin
            exInstr = idInstr();
            if (halt_in_1) haltEntered = 1'b1;
         end
      end
      #1;
      checkOutputs();
      @(negedge CLK);
   endtask

   initial begin
      setIdle();
      nRST = 1'b0;
      modelReset();

      // Reset, then first capture
      rs_in_1 = 5'd3; rt_in_1 = 5'd4; wsel_in_1 = 5'd5;
      rdat1_in_1 = 32'h11; imm_in_1 = 32'hFFFF_FFF0;
      RegWrite_in_1 = 1'b1; valid_in_1 = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      checkOutputs();
      chk("resetLuStall", {31'd0, luStall}, 32'd0);
      nRST = 1'b1;
      cycle();
      chk("capValid", {31'd0, valid_out_2}, 32'd1);
      chk("capRs", {27'd0, rs_out_2}, 32'd3);
      chk("capImm", imm_out_2, 32'hFFFF_FFF0);

      // Hold with changing inputs
      for (int i = 0; i < 3; i++) begin
         randomInputs();
         en = 1'b0;
         halt_in_1 = 1'b0;
         cycle();
      end
      chk("holdRs", {27'd0, rs_out_2}, 32'd3);
      chk("holdRdat1", rdat1_out_2, 32'h11);

      // Load-use: lw $8 in EX, add reading $8 in ID
      setIdle();
      valid_in_1 = 1'b1; dREN_in_1 = 1'b1; RegWrite_in_1 = 1'b1; wsel_in_1 = 5'd8;
      cycle();
      setIdle();
      valid_in_1 = 1'b1; RegWrite_in_1 = 1'b1; rs_in_1 = 5'd8; rt_in_1 = 5'd1;
      uses_rt_in_1 = 1'b1; wsel_in_1 = 5'd10;
      #1 chk("luAssert", {31'd0, luStall}, 32'd1);
      cycle();
      chk("luBubbleValid", {31'd0, valid_out_2}, 32'd0);
      chk("luBubbleDren", {31'd0, dREN_out_2}, 32'd0);
      chk("luDrop", {31'd0, luStall}, 32'd0);
      cycle();
      chk("luCaptureRs", {27'd0, rs_out_2}, 32'd8);
      chk("luCaptureValid", {31'd0, valid_out_2}, 32'd1);

      // No false stall: load to $zero
      setIdle();
      valid_in_1 = 1'b1; dREN_in_1 = 1'b1; wsel_in_1 = 5'd0;
      cycle();
      setIdle();
      valid_in_1 = 1'b1; rs_in_1 = 5'd0;
      #1 chk("noStallZero", {31'd0, luStall}, 32'd0);
      // No false stall: rt matches but is not read
      dREN_in_1 = 1'b1; wsel_in_1 = 5'd9; rs_in_1 = 5'd2;
      cycle();
      setIdle();
      valid_in_1 = 1'b1; rs_in_1 = 5'd1; rt_in_1 = 5'd9; uses_rt_in_1 = 1'b0;
      #1 chk("noStallRt", {31'd0, luStall}, 32'd0);

      // Flush beats load-use
      uses_rt_in_1 = 1'b1;
      #1 chk("hazardArmed", {31'd0, luStall}, 32'd1);
      flush = 1'b1;
      cycle();
      chk("flushBubble", {31'd0, valid_out_2}, 32'd0);
      // Flush while not enabled holds
      setIdle();
      valid_in_1 = 1'b1; wsel_in_1 = 5'd7; pc4_in_1 = 32'h40;
      cycle();
      flush = 1'b1; en = 1'b0;
      cycle();
      chk("flushHeldValid", {31'd0, valid_out_2}, 32'd1);
      chk("flushHeldWsel", {27'd0, wsel_out_2}, 32'd7);

      // Halt sticky
      setIdle();
      valid_in_1 = 1'b1; halt_in_1 = 1'b1;
      cycle();
      chk("haltCaptured", {31'd0, halt_out_2}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         setIdle();
         valid_in_1 = 1'b1; RegWrite_in_1 = 1'b1; dWEN_in_1 = 1'b1;
         rs_in_1 = 5'(i + 1); pc4_in_1 = 32'(i * 4);
         cycle();
         chk("haltSticky", {31'd0, halt_out_2}, 32'd1);
         chk("haltNoValid", {31'd0, valid_out_2}, 32'd0);
         chk("haltNoRegWrite", {31'd0, RegWrite_out_2}, 32'd0);
         chk("haltNoDwen", {31'd0, dWEN_out_2}, 32'd0);
      end
      // Asynchronous reset mid-cycle
      #2 nRST = 1'b0;
      modelReset();
      #1 chk("asyncHalt", {31'd0, halt_out_2}, 32'd0);
      checkOutputs();
      @(negedge CLK);
      nRST = 1'b1;
      setIdle();
      valid_in_1 = 1'b1; rs_in_1 = 5'd6;
      cycle();
      chk("resumeRs", {27'd0, rs_out_2}, 32'd6);

      // Randomized run against the model, with periodic async resets
      for (int n = 0; n < 600; n++) begin
         randomInputs();
         if (n % 75 == 74) begin
            #2 nRST = 1'b0;
            modelReset();
            #1 checkOutputs();
            @(negedge CLK);
            nRST = 1'b1;
         end else begin
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

ID/EX pipeline register of the 5-stage MIPS pipeline, feeding the EX stage and the forwarding unit's stage-2 inputs (rs_out_2, rt_out_2, dREN_out_2, dWEN_out_2). It captures decoded fields on each pipeline advance and holds them on stall. It inserts a bubble on flush and on a load-use dependency, and asserts a one-cycle stall request back to IF/ID. It also makes halt sticky, so no instruction younger than a halt reaches EX.

## Interface
- No parameters; widths are fixed by cpu_types_pkg (regbits_t = 5 bits, word_t = 32 bits, aluop_t = 4 bits).
- CLK  in  1  pipeline clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance from the control unit. Register captures only when high.
- flush  in  1  squash. The next capture loads a bubble.
- valid_in_1, halt_in_1, RegWrite_in_1, dREN_in_1, dWEN_in_1, alusrc_in_1, uses_rt_in_1  in  1 each  decoded control bits from ID.
- rs_in_1, rt_in_1, wsel_in_1  in  5  source and destination register numbers from ID.
- aluop_in_1  in  4  ALU operation.
- rdat1_in_1, rdat2_in_1, imm_in_1, pc4_in_1  in  32 each  register-file data, extended immediate, PC+4.
- valid_out_2, halt_out_2, RegWrite_out_2, dREN_out_2, dWEN_out_2, alusrc_out_2  out  1 each  registered control bits.
- rs_out_2, rt_out_2, wsel_out_2  out  5  registered register numbers.
- aluop_out_2  out  4  registered ALU operation.
- rdat1_out_2, rdat2_out_2, imm_out_2, pc4_out_2  out  32 each  registered data.
- luStall  out  1  combinational load-use stall request to the PC and the IF/ID latch.

## Operation
- Bubble: valid, halt, RegWrite, dREN, dWEN, alusrc = 0; rs, rt, wsel = 0; aluop = 0; all 32-bit fields = 0.
- Load-use detect (combinational):
  - luStall = valid_out_2 & dREN_out_2 & (wsel_out_2 != 0) & valid_in_1 & ((wsel_out_2 == rs_in_1) | (uses_rt_in_1 & (wsel_out_2 == rt_in_1))).
  - luStall is forced to 0 when flush = 1 or halt_seen = 1.
- halt_seen: internal sticky flag. It sets on the edge that captures an instruction with halt_in_1 = 1 and clears only on reset.
- Update on the rising edge when en = 1, first matching rule wins:
  1. flush → load a bubble.
  2. halt_seen → load a bubble. halt_out_2 stays at 1 because halt_seen holds it sticky.
  3. luStall → load a bubble. IF/ID holds the dependent instruction because luStall gates its enable.
  4. otherwise → capture all *_in_1 fields into the *_out_2 registers.
- en = 0: all registers hold, including when flush = 1. Flush is sampled only on an enabled edge; the control unit holds it until en is seen.
- halt_out_2 = registered halt | halt_seen. It remains 1 after the halt instruction leaves the stage.
- wsel of 0 never triggers a stall: a load to $zero is treated as having no dependency.
- Only one bubble is inserted per load. After the bubble, dREN_out_2 = 0, so luStall drops and the dependent instruction is captured on the next enabled edge. The forwarding unit then supplies the load data from MEM/WB.

## Timing
- Reset (nRST low, asynchronous): every output register = 0 and halt_seen = 0. luStall then evaluates to 0.
- Latency: one enabled edge from *_in_1 to *_out_2.
- luStall is valid in the same cycle the load is in EX and the dependent instruction is in ID. It is asserted for exactly one enabled cycle per load-use pair.
- flush and luStall in the same cycle: flush wins, one bubble is inserted, and luStall reads 0.
- halt: the edge capturing halt_in_1 = 1 presents the halt instruction normally with halt_out_2 = 1. Every later enabled edge loads a bubble.
- Reset asserted mid-stall: outputs clear immediately, without waiting for a clock edge. Capture resumes on the first enabled edge after nRST rises.

## Test plan
- Reset/capture:
  - Stimulus: nRST low, then high. Drive rs = 3, rt = 4, wsel = 5, rdat1 = 0x11, imm = 0xFFFF_FFF0, RegWrite = 1, en = 1, then one edge.
  - Required: before the edge, every output is 0. After the edge, the outputs equal the inputs and valid_out_2 = 1.
- Hold:
  - Stimulus: en = 0 for 3 cycles with changing inputs.
  - Required: the outputs keep their prior values.
- Load-use:
  - Stimulus: EX holds lw with wsel = 8. ID holds add with rs = 8 and valid = 1.
  - Required: luStall = 1. The next edge loads a bubble (valid_out_2 = 0, dREN_out_2 = 0) and luStall drops to 0. The following edge captures the add with rs_out_2 = 8.
- No false stall:
  - Stimulus case 1: lw with wsel = 0 and rs = 0. Required: luStall = 0.
  - Stimulus case 2: lw with wsel = 9, ID rt = 9, uses_rt = 0. Required: luStall = 0.
- Flush priority:
  - Stimulus: flush = 1 together with a load-use condition and en = 1.
  - Required: luStall = 0 and one bubble is loaded.
  - Stimulus: flush = 1 with en = 0.
  - Required: the registers are unchanged.
- Halt sticky:
  - Stimulus: capture halt_in_1 = 1, then 4 enabled edges of valid instructions.
  - Required: halt_out_2 = 1 throughout, and valid/RegWrite/dWEN are 0 after the halt's cycle.
  - Stimulus: pulse nRST low mid-sequence.
  - Required: halt_out_2 = 0 asynchronously.
